// File: rtl/serial_addsub_nand.sv
// Bit-serial adder/subtractor: one NAND-only full adder/subtractor cell reused
// LSB-first over WIDTH clocks, with a start/busy/done handshake.

module serial_addsub_nand_xor (
    input  logic x,
    input  logic y,
    output logic z
);
    logic n0, n1, n2;

    nand g0 (n0, x, y);
    nand g1 (n1, x, n0);
    nand g2 (n2, y, n0);
    nand g3 (z, n1, n2);
endmodule

// Subtraction reuses the carry network with A inverted:
// borrow' = ~a&b | bw&(~a^b), so a_eff = a ^ sub feeds generate/propagate.
module serial_addsub_nand_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sub,
    output logic s,
    output logic cout
);
    logic p, a_eff, p_eff, g_n, t_n;

    serial_addsub_nand_xor u_xp  (.x(a),     .y(b),   .z(p));
    serial_addsub_nand_xor u_xs  (.x(p),     .y(cin), .z(s));
    serial_addsub_nand_xor u_xa  (.x(a),     .y(sub), .z(a_eff));
    serial_addsub_nand_xor u_xpe (.x(a_eff), .y(b),   .z(p_eff));

    nand g_gen  (g_n, a_eff, b);
    nand g_prop (t_n, cin, p_eff);
    nand g_or   (cout, g_n, t_n);
endmodule

module serial_addsub_nand #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, work;
    logic [WIDTH-1:0] work_nxt;
    logic [WIDTH:0]   work_ext;
    logic [CW-1:0]    cnt;
    logic             m_r, c_ff, a_msb, b_msb;
    logic             cell_s, cell_c, last, ovf_nxt;

    serial_addsub_nand_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c_ff),
        .sub  (m_r),
        .s    (cell_s),
        .cout (cell_c)
    );

    assign last     = (cnt == CW'(WIDTH - 1));
    assign work_ext = {cell_s, work};
    assign work_nxt = work_ext[WIDTH:1];

    // On the final step c_ff still holds the carry into the MSB.
    assign ovf_nxt = m_r ? ((a_msb ^ b_msb) & (cell_s ^ a_msb))
                         : (c_ff ^ cell_c);

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            work   <= '0;
            cnt    <= '0;
            m_r    <= 1'b0;
            c_ff   <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        m_r   <= mode;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        c_ff  <= 1'b0;
                        cnt   <= '0;
                        work  <= '0;
                    end
                end
                S_RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    c_ff <= cell_c;
                    work <= work_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        result <= work_nxt;
                        cout   <= cell_c;
                        ovf    <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_nand.sv
// Randomised and directed bench for serial_addsub_nand at WIDTH=8 and WIDTH=1,
// compared against an arithmetic reference model.

module tb_serial_addsub_nand;
    logic       clk;
    logic       rst_n;
    logic       start8, mode8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, result8;
    logic       start1, mode1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, result1;

    int total = 0;
    int bad   = 0;

    serial_addsub_nand #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8)
    );

    serial_addsub_nand #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: integer arithmetic, signed overflow from the true signed result.
    function automatic void model(input int w, input longint ua, input longint ub, input bit m,
                                  output logic [7:0] r, output logic c, output logic o);
        longint one, full, sa, sb, ss, smax, smin;
        one  = 1;
        sa   = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
        sb   = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
        smax = (one << (w - 1)) - 1;
        smin = -(one << (w - 1));
        if (!m) begin
            full = ua + ub;
            c    = (full >= (one << w));
            ss   = sa + sb;
        end else begin
            full = ua - ub;
            c    = (ua < ub);
            ss   = sa - sb;
        end
        r = 8'(full & ((one << w) - 1));
        o = (ss > smax) || (ss < smin);
    endfunction

    task automatic drive(input bit use1, input logic s, input logic [7:0] da,
                         input logic [7:0] db, input logic dm);
        if (use1) begin
            start1 = s; a1 = da[0:0]; b1 = db[0:0]; mode1 = dm;
        end else begin
            start8 = s; a8 = da; b8 = db; mode8 = dm;
        end
    endtask

    // {busy, done, cout, ovf, result}
    function automatic logic [11:0] obs(input bit use1);
        if (use1) return {busy1, done1, cout1, ovf1, 7'b0, result1};
        return {busy8, done8, cout8, ovf8, result8};
    endfunction

    // rp: cycle index after the start edge at which to re-pulse start
    // (0..w-1 lands in RUN, w lands in DONE, -1 for none).
    task automatic op(input bit use1, input logic [7:0] ta, input logic [7:0] tb,
                      input bit tm, input int rp, input string nm);
        int          w;
        logic [7:0]  mask, er;
        logic        ec, eo;
        logic [11:0] prev, cur;
        w    = use1 ? 1 : 8;
        mask = use1 ? 8'h01 : 8'hFF;
        model(w, longint'(ta & mask), longint'(tb & mask), tm, er, ec, eo);
        @(negedge clk);
        prev = obs(use1);
        drive(use1, 1'b1, ta & mask, tb & mask, tm);
        @(negedge clk);
        for (int k = 0; k < w; k++) begin
            cur = obs(use1);
            total++;
            if (cur !== {2'b10, prev[9:0]}) begin
                bad++;
                $display("FAIL %s run_k%0d: got busy/done/cout/ovf/res=%h want %h",
                         nm, k, cur, {2'b10, prev[9:0]});
            end
            if (k == rp) drive(use1, 1'b1, 8'h00, 8'h00, 1'b1);
            else drive(use1, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(negedge clk);
        end
        cur = obs(use1);
        total++;
        if (cur[11:10] !== 2'b01) begin
            bad++;
            $display("FAIL %s done_edge: busy,done=%b want 01", nm, cur[11:10]);
        end
        total++;
        if (cur[9:0] !== {ec, eo, er}) begin
            bad++;
            $display("FAIL %s value: cout,ovf,res=%b,%b,%h want %b,%b,%h",
                     nm, cur[9], cur[8], cur[7:0], ec, eo, er);
        end
        if (rp == w) drive(use1, 1'b1, 8'h00, 8'h00, 1'b1);
        else drive(use1, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        cur = obs(use1);
        total++;
        if (cur !== {2'b00, ec, eo, er}) begin
            bad++;
            $display("FAIL %s after_done: got %h want %h", nm, cur, {2'b00, ec, eo, er});
        end
        drive(use1, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        total++;
        if (obs(1'b0) !== 12'h000 || obs(1'b1) !== 12'h000) begin
            bad++;
            $display("FAIL reset_state: w8=%h w1=%h want 000", obs(1'b0), obs(1'b1));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        op(1'b0, 8'h3C, 8'h0F, 1'b0, -1, "add_3c_0f");
        op(1'b0, 8'hFF, 8'h01, 1'b0, -1, "add_ff_01");
        op(1'b0, 8'h7F, 8'h01, 1'b0, -1, "add_7f_01");
    endtask

    task automatic test_sub;
        op(1'b0, 8'h05, 8'h07, 1'b1, -1, "sub_05_07");
        op(1'b0, 8'h80, 8'h01, 1'b1, -1, "sub_80_01");
        op(1'b0, 8'h55, 8'h55, 1'b1, -1, "sub_55_55");
    endtask

    task automatic test_ignore_start;
        op(1'b0, 8'h12, 8'h34, 1'b0, 3, "restart_in_run");
        op(1'b0, 8'hC8, 8'h3A, 1'b1, 8, "restart_in_done");
    endtask

    task automatic test_reset_mid_run;
        int seen;
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hAA, 8'h11, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        total++;
        if (busy8 !== 1'b1) begin
            bad++;
            $display("FAIL midrun_busy: busy=%b want 1", busy8);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (obs(1'b0) !== 12'h000) begin
            bad++;
            $display("FAIL midrun_reset_clear: got %h want 000", obs(1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy8 !== 1'b0 || done8 !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrun_no_done: busy/done active %0d cycles want 0", seen);
        end
        op(1'b0, 8'h01, 8'h02, 1'b0, -1, "post_reset_add");
    endtask

    task automatic test_width1;
        op(1'b1, 8'h01, 8'h01, 1'b0, -1, "w1_add_1_1");
        op(1'b1, 8'h00, 8'h01, 1'b1, -1, "w1_sub_0_1");
        op(1'b1, 8'h01, 8'h00, 1'b1, 0, "w1_sub_1_0_restart");
        for (int i = 0; i < 8; i++)
            op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), -1, "w1_rand");
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++)
            op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1, "w8_rand");
    endtask

    task automatic test_back_to_back;
        op(1'b0, 8'h80, 8'h80, 1'b0, -1, "b2b_add_80_80");
        op(1'b0, 8'h7F, 8'hFF, 1'b1, -1, "b2b_sub_7f_ff");
        op(1'b0, 8'h00, 8'h00, 1'b0, -1, "b2b_add_0_0");
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_ignore_start;
        test_reset_mid_run;
        test_width1;
        test_random;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
